// File: rtl/tdm_demux4.sv
// Receive end of a 4-slot TDM link: locks onto the frame sync, collects one
// sample per slot and presents each complete frame on four parallel outputs.
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] x0,
    output logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] x3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [WIDTH-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
    logic             frame_valid_q, frame_valid_d;
    logic             locked_q, locked_d;
    logic             sync_err_q, sync_err_d;

    // Next-state logic: everything holds on a stall, only the pulses drop.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        s0_d          = s0_q;
        s1_d          = s1_q;
        s2_d          = s2_q;
        x0_d          = x0_q;
        x1_d          = x1_q;
        x2_d          = x2_q;
        x3_d          = x3_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        s0_d    = din;
                        slot_d  = 2'd1;
                        state_d = LOCKED;
                    end else begin
                        slot_d = 2'd0;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // A sync outside slot 0 abandons the partial frame and restarts it.
                        sync_err_d = (slot_q != 2'd0);
                        s0_d       = din;
                        slot_d     = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd0: begin
                                sync_err_d = 1'b1;
                                state_d    = HUNT;
                                slot_d     = 2'd0;
                            end
                            2'd1: begin
                                s1_d   = din;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                s2_d   = din;
                                slot_d = 2'd3;
                            end
                            2'd3: begin
                                x0_d          = s0_q;
                                x1_d          = s1_q;
                                x2_d          = s2_q;
                                x3_d          = din;
                                frame_valid_d = 1'b1;
                                slot_d        = 2'd0;
                            end
                            default: begin
                                slot_d = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end else begin
            slot_d = slot_q;
        end
        locked_d = (state_d == LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            s0_q          <= '0;
            s1_q          <= '0;
            s2_q          <= '0;
            x0_q          <= '0;
            x1_q          <= '0;
            x2_q          <= '0;
            x3_q          <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            s0_q          <= s0_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            x0_q          <= x0_d;
            x1_q          <= x1_d;
            x2_q          <= x2_d;
            x3_q          <= x3_d;
            frame_valid_q <= frame_valid_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign x0          = x0_q;
    assign x1          = x1_q;
    assign x2          = x2_q;
    assign x3          = x3_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule
